// File: rtl/hist_map_if.sv
// Bundles the CDF input stream, the gray pixel stream and the mapped output
// signals of hist_map. The slave modport is the block itself.
interface hist_map_if;
  logic [7:0]  pixel_level;
  logic [19:0] pixel_level_acc_num;
  logic        pixel_level_valid;
  logic        img_vsync;
  logic        img_href;
  logic [7:0]  img_gray;
  logic        post_img_vsync;
  logic        post_img_href;
  logic [7:0]  post_img_gray;
  logic        lut_ready;
  logic        table_err;

  modport slave (
    input  pixel_level, pixel_level_acc_num, pixel_level_valid,
    input  img_vsync, img_href, img_gray,
    output post_img_vsync, post_img_href, post_img_gray, lut_ready, table_err
  );

  modport master (
    output pixel_level, pixel_level_acc_num, pixel_level_valid,
    output img_vsync, img_href, img_gray,
    input  post_img_vsync, post_img_href, post_img_gray, lut_ready, table_err
  );
endinterface

// File: rtl/hist_map.sv
// Turns a per-frame cumulative histogram into a double-buffered 256-entry
// equalisation LUT and applies the committed table to the gray pixel stream.
module hist_map #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int SCALE_SHIFT = 24
) (
  input logic       clk,
  input logic       rst_n,
  hist_map_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a level-0 entry to start a capture
  // CAPT  | accepting levels in ascending order into the inactive bank
  // DONE  | complete table in the inactive bank, waiting for a vsync commit
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAPT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam longint unsigned TOTAL      = longint'(IMG_WIDTH) * longint'(IMG_HEIGHT);
  localparam longint unsigned SCALE_FULL = ((64'd255 << SCALE_SHIFT) + TOTAL - 64'd1) / TOTAL;
  localparam int              SCALE_W    = 32;
  localparam int              PROD_W     = 20 + SCALE_W;
  localparam logic [SCALE_W-1:0] SCALE   = SCALE_FULL[SCALE_W-1:0];

  logic [1:0]        state_q, state_d;
  logic [7:0]        exp_q, exp_d;
  logic              pending_q, pending_d;
  logic              commit_q, commit_d;
  logic              bank_q, bank_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              accept, lvl0;

  logic              s1_vld_q;
  logic [7:0]        s1_level_q;
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] prod_sh;
  logic [7:0]        map_val;

  logic              vs_d1_q, vs_d2_q, href_d1_q, href_d2_q, ready_d1_q;
  logic [7:0]        gray_d1_q, rd_q, out_q;
  logic              vs_rise;

  logic [7:0]        lut_mem [0:511];

  assign vs_rise = bus.img_vsync & ~vs_d1_q;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    pending_d = pending_q;
    commit_d  = commit_q;
    bank_d    = bank_q;
    ready_d   = ready_q;
    err_d     = 1'b0;
    accept    = 1'b0;
    lvl0      = bus.pixel_level_valid && (bus.pixel_level == 8'd0);

    case (state_q)
      S_IDLE: begin
        if (lvl0) begin
          accept  = 1'b1;
          exp_d   = 8'd1;
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (vs_rise) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.pixel_level_valid) begin
          if (bus.pixel_level == exp_q) begin
            accept = 1'b1;
            exp_d  = exp_q + 8'd1;
            if (exp_q == 8'd255) begin
              state_d   = S_DONE;
              pending_d = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            if (lvl0) begin
              accept  = 1'b1;
              exp_d   = 8'd1;
              state_d = S_CAPT;
            end
          end
        end
      end
      S_DONE: begin
        if (lvl0) begin
          accept    = 1'b1;
          exp_d     = 8'd1;
          pending_d = 1'b0;
          state_d   = S_CAPT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A commit request waits until the last LUT write has left the pipeline.
    if (!pending_d)   commit_d = 1'b0;
    else if (vs_rise) commit_d = 1'b1;
    if (commit_d && !s1_vld_q) begin
      bank_d    = ~bank_q;
      pending_d = 1'b0;
      commit_d  = 1'b0;
      ready_d   = 1'b1;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      exp_q     <= 8'd0;
      pending_q <= 1'b0;
      commit_q  <= 1'b0;
      bank_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      pending_q <= pending_d;
      commit_q  <= commit_d;
      bank_q    <= bank_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_level_q <= 8'd0;
      prod_q     <= '0;
    end else begin
      s1_vld_q   <= accept;
      s1_level_q <= bus.pixel_level;
      prod_q     <= {{(PROD_W-20){1'b0}}, bus.pixel_level_acc_num} *
                    {{(PROD_W-SCALE_W){1'b0}}, SCALE};
    end
  end

  assign prod_sh = prod_q >> SCALE_SHIFT;
  assign map_val = (|prod_sh[PROD_W-1:8]) ? 8'hFF : prod_sh[7:0];

  always_ff @(posedge clk) begin
    if (s1_vld_q) lut_mem[{~bank_q, s1_level_q}] <= map_val;
    rd_q <= lut_mem[{bank_q, bus.img_gray}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1_q    <= 1'b0;
      vs_d2_q    <= 1'b0;
      href_d1_q  <= 1'b0;
      href_d2_q  <= 1'b0;
      ready_d1_q <= 1'b0;
      gray_d1_q  <= 8'd0;
      out_q      <= 8'd0;
    end else begin
      vs_d1_q    <= bus.img_vsync;
      vs_d2_q    <= vs_d1_q;
      href_d1_q  <= bus.img_href;
      href_d2_q  <= href_d1_q;
      ready_d1_q <= ready_q;
      gray_d1_q  <= bus.img_gray;
      out_q      <= !href_d1_q ? 8'd0 : (ready_d1_q ? rd_q : gray_d1_q);
    end
  end

  assign bus.post_img_vsync = vs_d2_q;
  assign bus.post_img_href  = href_d2_q;
  assign bus.post_img_gray  = out_q;
  assign bus.lut_ready      = ready_q;
  assign bus.table_err      = err_q;
endmodule

// File: tb/tb_hist_map.sv
// Randomised scoreboard bench for hist_map: a table-level model predicts each
// mapped pixel and its output cycle; a monitor pops and compares.
module tb_hist_map;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hist_map_if bus();

  hist_map #(.IMG_WIDTH(640), .IMG_HEIGHT(480), .SCALE_SHIFT(24)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam longint unsigned TOTAL_REF = 640 * 480;
  localparam longint unsigned SCALE_REF = ((64'd255 << 24) + TOTAL_REF - 1) / TOTAL_REF;

  typedef struct packed {
    int         c;
    logic [7:0] g;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0, live = 0;
  int          n_chk = 0, n_pass = 0;
  int          err_seen = 0, err_exp = 0;
  logic        vs_hist[4];
  logic [7:0]  act_lut[256];
  logic [7:0]  pend_lut[256];
  bit          m_ready = 0, m_pend = 0, cur_vs = 0;
  int          m_next = -1;
  logic [19:0] cdf[256];
  logic [7:0]  px[$];

  task automatic check(input string name, input longint got, input longint expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  function automatic logic [7:0] ref_map(input logic [19:0] acc);
    longint unsigned p;
    p = (longint'(acc) * SCALE_REF) >> 24;
    if (p > 255) return 8'd255;
    return p[7:0];
  endfunction

  task automatic model_entry(input logic [7:0] lvl, input logic [19:0] acc);
    if (m_next >= 0 && int'(lvl) != m_next) begin
      err_exp++;
      m_next = -1;
    end
    if (m_next >= 0) begin
      pend_lut[lvl] = ref_map(acc);
      if (lvl == 8'd255) begin
        m_next = -1;
        m_pend = 1;
      end else m_next++;
    end else if (lvl == 8'd0) begin
      m_pend      = 0;
      pend_lut[0] = ref_map(acc);
      m_next      = 1;
    end
  endtask

  task automatic model_vs_rise();
    if (m_next >= 0) begin
      err_exp++;
      m_next = -1;
    end
    if (m_pend) begin
      act_lut = pend_lut;
      m_ready = 1;
      m_pend  = 0;
    end
  endtask

  task automatic cycle(input bit vs, input bit hr, input logic [7:0] g,
                       input bit cv, input logic [7:0] lvl, input logic [19:0] acc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.img_vsync           = vs;
    bus.img_href            = hr;
    bus.img_gray            = g;
    bus.pixel_level_valid   = cv;
    bus.pixel_level         = lvl;
    bus.pixel_level_acc_num = acc;
    vs_hist[cyc % 4]        = vs;
    if (vs && !cur_vs) model_vs_rise();
    cur_vs = vs;
    if (cv) model_entry(lvl, acc);
    if (hr) begin
      e.c = cyc + 2;
      e.g = m_ready ? act_lut[g] : g;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(cur_vs, 0, 8'($urandom_range(0, 255)), 0, 8'd0, 20'd0);
  endtask

  task automatic frame(input logic [7:0] pix[$]);
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'd0, 0, 8'd0, 20'd0);
    foreach (pix[i]) begin
      if ($urandom_range(0, 7) == 0) cycle(1, 0, 8'($urandom_range(0, 255)), 0, 8'd0, 20'd0);
      cycle(1, 1, pix[i], 0, 8'd0, 20'd0);
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'd0, 0, 8'd0, 20'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'd0, 0, 8'd0, 20'd0);
    check("sb_drained", sbq.size(), 0);
  endtask

  task automatic send_cdf(input bit vs, input int last, input int bad);
    for (int l = 0; l <= last; l++) cycle(vs, 0, 8'd0, 1, 8'(l), cdf[l]);
    if (bad >= 0) cycle(vs, 0, 8'd0, 1, 8'(bad), cdf[bad]);
    cycle(vs, 0, 8'd0, 0, 8'd0, 20'd0);
  endtask

  task automatic rand_cdf();
    int a = 0;
    for (int l = 0; l < 256; l++) begin
      a += int'($urandom_range(0, 2600));
      if (a > 1048575) a = 1048575;
      cdf[l] = 20'(a);
    end
  endtask

  task automatic rand_px(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(8'($urandom_range(0, 255)));
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n) live++;
    else live = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.table_err) err_seen++;
    if (rst_n && live >= 3) begin
      check("post_vsync", bus.post_img_vsync, vs_hist[(cyc + 2) % 4]);
      if (bus.post_img_href) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected_pixel: got gray %0d at cycle %0d, expected none",
                   bus.post_img_gray, cyc);
        end else begin
          e = sbq.pop_front();
          check("pix_cycle", cyc, e.c);
          check("pix_gray", bus.post_img_gray, e.g);
        end
      end else begin
        check("idle_gray_zero", bus.post_img_gray, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) vs_hist[i] = 1'b0;
    bus.img_vsync = 0; bus.img_href = 0; bus.img_gray = 0;
    bus.pixel_level_valid = 0; bus.pixel_level = 0; bus.pixel_level_acc_num = 0;

    idle(3);
    check("rst_post_vsync", bus.post_img_vsync, 0);
    check("rst_post_href", bus.post_img_href, 0);
    check("rst_post_gray", bus.post_img_gray, 0);
    check("rst_lut_ready", bus.lut_ready, 0);
    check("rst_table_err", bus.table_err, 0);
    rst_n = 1'b1;
    idle(4);

    // pass-through before any table
    px.delete();
    for (int i = 0; i < 24; i++) px.push_back(8'd37);
    frame(px);
    check("ready_before_table", bus.lut_ready, 0);

    // single-level CDF
    for (int l = 0; l < 256; l++) cdf[l] = (l < 100) ? 20'd0 : 20'd307200;
    send_cdf(0, 255, -1);
    rand_px(20);
    px.push_front(8'd200); px.push_front(8'd100); px.push_front(8'd50);
    frame(px);
    check("ready_after_commit", bus.lut_ready, 1);

    // linear CDF, every level exercised
    for (int l = 0; l < 256; l++) cdf[l] = 20'((l + 1) * 1200);
    send_cdf(0, 255, -1);
    px.delete();
    for (int i = 0; i < 256; i++) px.push_back(8'(i));
    frame(px);

    // interrupted stream keeps the linear table
    send_cdf(0, 99, 150);
    rand_px(40);
    frame(px);
    check("err_after_gap", err_seen, err_exp);

    // two complete streams, second one wins
    rand_cdf();
    send_cdf(0, 255, -1);
    rand_cdf();
    send_cdf(0, 255, -1);
    rand_px(48);
    frame(px);

    // capture still running when vsync rises
    rand_cdf();
    send_cdf(0, 40, -1);
    rand_px(40);
    frame(px);
    check("err_after_vsync_abort", err_seen, err_exp);
    check("ready_kept", bus.lut_ready, 1);

    // reset mid-frame during a capture
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'd0, 0, 8'd0, 20'd0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 8'($urandom_range(0, 255)), 0, 8'd0, 20'd0);
    for (int l = 0; l <= 50; l++) cycle(1, 0, 8'd0, 1, 8'(l), cdf[l]);
    rst_n = 1'b0;
    #1;
    check("midrst_post_href", bus.post_img_href, 0);
    check("midrst_post_vsync", bus.post_img_vsync, 0);
    check("midrst_post_gray", bus.post_img_gray, 0);
    check("midrst_lut_ready", bus.lut_ready, 0);
    sbq.delete();
    m_ready = 0; m_pend = 0; m_next = -1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'd0, 0, 8'd0, 20'd0);
    rst_n = 1'b1;
    idle(4);
    rand_px(32);
    frame(px);
    check("ready_after_reset", bus.lut_ready, 0);

    idle(4);
    check("err_total", err_seen, err_exp);
    check("sb_final_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hist_map.md
Name: hist_map

Overview:
- Consumer of the cumulative-histogram stream produced at each frame end (pixel_level, pixel_level_acc_num, pixel_level_valid).
- Converts each CDF entry into a 256-entry equalisation LUT.
- Double-buffers the LUT and applies the committed table to the next frame's gray pixel stream.
- Sits after the histogram statistics block; its pixel output feeds downstream display/processing.

Parameters:
IMG_WIDTH, 640, active pixels per line
IMG_HEIGHT, 480, active lines per frame; TOTAL = IMG_WIDTH*IMG_HEIGHT, must be <= 2^20-1
SCALE_SHIFT, 24, fixed-point shift for the reciprocal scale; SCALE = ceil(255*2^SCALE_SHIFT / TOTAL), computed at elaboration

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pixel_level  in  8  CDF entry index
pixel_level_acc_num  in  20  cumulative pixel count up to and including pixel_level
pixel_level_valid  in  1  CDF entry strobe; one entry per cycle, level 0..255 ascending
img_vsync  in  1  input frame sync, high during frame
img_href  in  1  input pixel valid
img_gray  in  8  input gray pixel
post_img_vsync  out  1  img_vsync delayed 2 cycles
post_img_href  out  1  img_href delayed 2 cycles
post_img_gray  out  8  mapped pixel, aligned with post_img_href
lut_ready  out  1  high once any table has been committed
table_err  out  1  one-cycle pulse when a CDF capture is aborted

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst_n asynchronous assert, synchronous-release usage.
  - Reset values: all outputs 0; active bank = 0; capture state IDLE; pending flag 0.
- Mapping arithmetic, pipelined, 2 cycles from pixel_level_valid to LUT write:
  - Stage 1: prod = acc_num * SCALE, full width, no truncation.
  - Stage 2: m = prod >> SCALE_SHIFT, saturated to 255.
  - Write m at address pixel_level into the inactive bank.
- Capture FSM, states IDLE / CAPTURE / DONE:
  - IDLE: a valid entry with level 0 starts capture: write it, exp <= 1, go to CAPTURE. Any valid entry with level != 0 is ignored.
  - CAPTURE, valid with level == exp: write it, exp++. Level 255 -> DONE and set pending.
  - CAPTURE, valid with level != exp: pulse table_err, go to IDLE, discard the partial table (pending stays 0). If that level is 0, restart capture in the same cycle.
  - CAPTURE, rising edge of img_vsync seen before level 255: table_err pulse, go to IDLE.
  - DONE: a new level-0 entry overwrites the inactive bank, clears pending, re-enters CAPTURE (the newer table wins).
- Commit:
  - On a registered rising edge of img_vsync with pending = 1: swap active bank, clear pending, set lut_ready (sticky until reset), FSM -> IDLE.
  - The swap never happens mid-frame, so a frame always uses one table.
  - A swap on the same cycle as a stage-2 write: that write still lands in the old inactive bank, now active. Both writes are drained before the swap is taken; the commit is delayed up to 2 cycles if the pipeline is non-empty.
- Pixel path:
  - img_gray addresses the active bank (synchronous read, 1 cycle), then one output register: 2-cycle latency.
  - post_img_vsync and post_img_href are delayed 2 cycles, matching the data.
  - lut_ready = 0: post_img_gray = img_gray delayed 2 (pass-through).
  - post_img_href = 0: post_img_gray = 0.
- Reset mid-capture or mid-frame: everything returns to reset values; the table is lost and pass-through resumes.
- Storage: 2 x 256 x 8 RAM, or one 512 x 8 dual-port RAM with the bank bit as MSB. Write port is the capture path; read port is the pixel path.

Test Plan:
- Reset -> all outputs 0; a frame of img_gray = 37 with href -> post_img_gray = 37 at 2-cycle latency, lut_ready = 0.
- Single-level CDF: acc = 0 for levels 0..99, 307200 for levels 100..255; next vsync rise -> lut_ready = 1. Next frame: gray 50 -> 0, gray 100 -> 255, gray 200 -> 255.
- Linear CDF, acc = (level+1)*1200 -> level 0 maps to 0 (16712400>>24), level 1 -> 1, level 255 -> 255. Check all 256 entries against floor(acc*13927 >> 24).
- Interrupted stream: levels 0..99 then level 150 -> table_err pulse. Next vsync rise -> no swap, previous LUT still applied.
- Two complete CDF streams before one vsync rise -> the second table is committed; a capture still in progress when vsync rises -> error, old table kept.
- rst_n asserted mid-frame during CAPTURE -> outputs 0 immediately, lut_ready = 0, pass-through on the next frame.
